// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle between the writeback producers, the arbiter and the register-file write port.
// The master modport drives requests and queries; the slave modport is the arbiter side.
interface regfile_wb_arbiter_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          a_valid;
  logic          a_ready;
  logic [4:0]    a_addr;
  logic [31:0]   a_data;
  logic          b_valid;
  logic          b_ready;
  logic [4:0]    b_addr;
  logic [31:0]   b_data;
  logic [4:0]    q_addr1;
  logic [4:0]    q_addr2;
  logic          q_busy1;
  logic          q_busy2;
  logic [CW-1:0] fifo_count;
  logic [4:0]    wAddr;
  logic [31:0]   wDin;
  logic          wEna;

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data, q_addr1, q_addr2,
    input  a_ready, b_ready, q_busy1, q_busy2, fifo_count, wAddr, wDin, wEna
  );

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data, q_addr1, q_addr2,
    output a_ready, b_ready, q_busy1, q_busy2, fifo_count, wAddr, wDin, wEna
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: port A (pipeline) has priority, port B is queued in a FIFO with a starvation limit.
// Optional macro WB_DROP_R0_EN discards writes to r0 on both ports.
module regfile_wb_arbiter #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  regfile_wb_arbiter_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [4:0]    w_addr_q, w_addr_d;
  logic [31:0]   w_din_q, w_din_d;
  logic          w_ena_q, w_ena_d;

  logic          empty;
  logic          a_ready;
  logic          b_ready;
  logic          a_take;
  logic          a_win;
  logic          b_push;
  logic          pop;
  logic          busy1;
  logic          busy2;
  logic [AW-1:0] idx;

  assign empty   = (count_q == '0);
  assign a_ready = (starve_q < SW'(STARVE_MAX));
  assign b_ready = (count_q < CW'(DEPTH));
  assign a_take  = bus.a_valid && a_ready;

`ifdef WB_DROP_R0_EN
  // r0 writes are accepted but vanish; a dropped A write leaves the slot to the FIFO head
  assign a_win  = a_take && (bus.a_addr != 5'd0);
  assign b_push = bus.b_valid && b_ready && (bus.b_addr != 5'd0);
`else
  assign a_win  = a_take;
  assign b_push = bus.b_valid && b_ready;
`endif

  assign pop = !empty && !a_win;

  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    starve_d = '0;
    w_addr_d = w_addr_q;
    w_din_d  = w_din_q;
    w_ena_d  = 1'b0;

    if (pop)    head_d = head_q + AW'(1);
    if (b_push) tail_d = tail_q + AW'(1);

    case ({b_push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (!empty && a_win) starve_d = starve_q + SW'(1);

    if (a_win) begin
      w_addr_d = bus.a_addr;
      w_din_d  = bus.a_data;
      w_ena_d  = 1'b1;
    end else if (pop) begin
      w_addr_d = mem_q[head_q].addr;
      w_din_d  = mem_q[head_q].data;
      w_ena_d  = 1'b1;
    end
  end

  // Only stored entries count; the popped entry already sits in the output register
  always_comb begin
    busy1 = 1'b0;
    busy2 = 1'b0;
    idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count_q) begin
        idx = head_q + AW'(i);
        if (mem_q[idx].addr == bus.q_addr1) busy1 = 1'b1;
        if (mem_q[idx].addr == bus.q_addr2) busy2 = 1'b1;
      end
    end
`ifdef WB_DROP_R0_EN
    if (bus.q_addr1 == 5'd0) busy1 = 1'b0;
    if (bus.q_addr2 == 5'd0) busy2 = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      starve_q <= '0;
      w_addr_q <= '0;
      w_din_q  <= '0;
      w_ena_q  <= 1'b0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      w_addr_q <= w_addr_d;
      w_din_q  <= w_din_d;
      w_ena_q  <= w_ena_d;
    end
  end

  always_ff @(posedge clk) begin
    if (b_push) mem_q[tail_q] <= '{addr: bus.b_addr, data: bus.b_data};
  end

  assign bus.a_ready    = a_ready;
  assign bus.b_ready    = b_ready;
  assign bus.q_busy1    = busy1;
  assign bus.q_busy2    = busy2;
  assign bus.fifo_count = count_q;
  assign bus.wAddr      = w_addr_q;
  assign bus.wDin       = w_din_q;
  assign bus.wEna       = w_ena_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: a queue-based reference model predicts each register-file
// write and the handshake/query outputs; a separate monitor compares writes as the DUT presents them.
module tb_regfile_wb_arbiter;
  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.DEPTH(DEPTH)) bus ();

  regfile_wb_arbiter #(
    .DEPTH     (DEPTH),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    int          due;
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } ent_t;

  wr_t  exp_q [$];
  ent_t fifo_m [$];
  int   starve_m    = 0;
  int   cyc         = 0;
  int   vectors     = 0;
  int   miscompares = 0;
  logic a_acc       = 1'b0;
  logic b_acc       = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, req);
    end
  endtask

  function automatic logic busyModel(input logic [4:0] a);
    logic hit = 1'b0;
`ifdef WB_DROP_R0_EN
    if (a == 5'd0) return 1'b0;
`endif
    foreach (fifo_m[i]) if (fifo_m[i].addr == a) hit = 1'b1;
    return hit;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: checks combinational outputs, then advances one cycle of arbitration
  always @(negedge clk) begin : model
    logic ar, br, aw, pp, keep_b;
    int   sz;
    ent_t e;
    if (rst_n) begin
      ar = (starve_m < STARVE_MAX);
      br = (fifo_m.size() < DEPTH);
      sz = fifo_m.size();
      checkOutput("a_ready", 32'(bus.a_ready), 32'(ar));
      checkOutput("b_ready", 32'(bus.b_ready), 32'(br));
      checkOutput("fifo_count", 32'(bus.fifo_count), 32'(sz));
      checkOutput("q_busy1", 32'(bus.q_busy1), 32'(busyModel(bus.q_addr1)));
      checkOutput("q_busy2", 32'(bus.q_busy2), 32'(busyModel(bus.q_addr2)));

      a_acc  = bus.a_valid && ar;
      b_acc  = bus.b_valid && br;
      aw     = a_acc;
      keep_b = 1'b1;
`ifdef WB_DROP_R0_EN
      aw     = a_acc && (bus.a_addr != 5'd0);
      keep_b = (bus.b_addr != 5'd0);
`endif
      pp = (sz > 0) && !aw;
      if (aw) begin
        exp_q.push_back('{cyc + 1, bus.a_addr, bus.a_data});
      end else if (pp) begin
        e = fifo_m.pop_front();
        exp_q.push_back('{cyc + 1, e.addr, e.data});
      end
      if (b_acc && keep_b) fifo_m.push_back('{addr: bus.b_addr, data: bus.b_data});
      starve_m = ((sz > 0) && aw) ? starve_m + 1 : 0;
    end
  end

  always @(negedge clk) begin : monitor
    wr_t w;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      w = exp_q.pop_front();
      checkOutput("wEna", 32'(bus.wEna), 32'd1);
      checkOutput("wAddr", 32'(bus.wAddr), 32'(w.addr));
      checkOutput("wDin", bus.wDin, w.data);
    end else begin
      checkOutput("wEna_idle", 32'(bus.wEna), 32'd0);
    end
  end

  task automatic driveCycle(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                            input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                            input logic [4:0] q1, input logic [4:0] q2);
    bus.a_valid = av;
    bus.a_addr  = aa;
    bus.a_data  = ad;
    bus.b_valid = bv;
    bus.b_addr  = ba;
    bus.b_data  = bd;
    bus.q_addr1 = q1;
    bus.q_addr2 = q2;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) driveCycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
  endtask

  // Random traffic; a request is only replaced once the arbiter has accepted it
  task automatic applyStimulus(input int n, input int a_pct, input int b_pct, input int span);
    for (int i = 0; i < n; i++) begin
      if (!(bus.a_valid && !a_acc)) begin
        bus.a_valid = ($urandom_range(99) < a_pct);
        bus.a_addr  = 5'($urandom_range(span - 1));
        bus.a_data  = $urandom;
      end
      if (!(bus.b_valid && !b_acc)) begin
        bus.b_valid = ($urandom_range(99) < b_pct);
        bus.b_addr  = 5'($urandom_range(span - 1));
        bus.b_data  = $urandom;
      end
      bus.q_addr1 = 5'($urandom_range(span - 1));
      bus.q_addr2 = 5'($urandom_range(span - 1));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    exp_q.delete();
    fifo_m.delete();
    starve_m = 0;
    #1;
    checkOutput("rst_wEna", 32'(bus.wEna), 32'd0);
    checkOutput("rst_fifo_count", 32'(bus.fifo_count), 32'd0);
    checkOutput("rst_b_ready", 32'(bus.b_ready), 32'd1);
    checkOutput("rst_a_ready", 32'(bus.a_ready), 32'd1);
    idle(2);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [4:0] aa, ba;
    bus.a_valid = 1'b0; bus.a_addr = '0; bus.a_data = '0;
    bus.b_valid = 1'b0; bus.b_addr = '0; bus.b_data = '0;
    bus.q_addr1 = '0;   bus.q_addr2 = '0;
    @(posedge clk);
    #1;
    doReset();
    idle(2);

    $display("[TB] single A write to r5");
    driveCycle(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
    idle(3);

    $display("[TB] B fill to full and drain, querying r3");
    aa = 5'd20;
    ba = 5'd1;
    for (int i = 0; i < 16; i++) begin
      if (i > 0 && a_acc) aa = aa + 5'd1;
      if (i > 0 && b_acc) ba = ba + 5'd1;
      driveCycle(i < 7, aa, {27'd0, aa}, ba <= 5'd5, ba, 32'h100 + 32'(ba), 5'd3, ba);
    end
    idle(8);

    $display("[TB] starvation of a single queued r7");
    driveCycle(1'b1, 5'd10, 32'hA0, 1'b1, 5'd7, 32'hAA, 5'd7, 5'd10);
    aa = 5'd10;
    for (int i = 0; i < 12; i++) begin
      if (a_acc) aa = aa + 5'd1;
      driveCycle(1'b1, aa, 32'hA0 + 32'(aa), 1'b0, 5'd0, 32'd0, 5'd7, aa);
    end
    idle(4);

    $display("[TB] r0 writes on both ports");
    driveCycle(1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    idle(2);
    driveCycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h66, 5'd0, 5'd0);
    idle(3);

    $display("[TB] random traffic");
    applyStimulus(400, 60, 50, 8);
    applyStimulus(400, 90, 85, 32);
    applyStimulus(300, 30, 90, 4);
    idle(8);

    $display("[TB] reset with queued entries and a pending write");
    for (int i = 0; i < 3; i++)
      driveCycle(1'b1, 5'(12 + i), 32'hC0 + 32'(i), 1'b1, 5'(1 + i), 32'hB0 + 32'(i), 5'd1, 5'd2);
    doReset();
    idle(3);
    applyStimulus(200, 70, 70, 8);
    idle(10);

    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Writeback-stage arbiter directly upstream of the 32x32 register file; drives its single write port (wAddr/wDin/wEna).
- Merges two sources:
  - the in-order pipeline writeback (port A, highest priority);
  - a long-latency unit such as load-miss or mul/div completion (port B, valid/ready), buffered in a small FIFO.
- Exposes a busy query so the issue stage stalls on registers with queued B writes.

Parameters:
- DEPTH, 4, port-B FIFO entries; power of two, >= 2
- STARVE_MAX, 8, consecutive cycles a non-empty FIFO head may lose to A before A is held off; >= 1

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-low
- a_valid  in  1  port A write request
- a_ready  out  1  port A accepted; upstream holds a_valid/a_addr/a_data while a_valid && !a_ready
- a_addr  in  5  port A destination register
- a_data  in  32  port A write data
- b_valid  in  1  port B write request
- b_ready  out  1  FIFO has space
- b_addr  in  5  port B destination register
- b_data  in  32  port B write data
- q_addr1  in  5  busy query address 1 (rs)
- q_addr2  in  5  busy query address 2 (rt)
- q_busy1  out  1  q_addr1 matches a stored FIFO entry
- q_busy2  out  1  q_addr2 matches a stored FIFO entry
- fifo_count  out  $clog2(DEPTH)+1  stored entries
- wAddr  out  5  register-file write address (registered)
- wDin  out  32  register-file write data (registered)
- wEna  out  1  register-file write enable (registered)

Behaviour:
- Reset (async, rst_n low):
  - wEna=0, wAddr=0, wDin=0.
  - FIFO empty: fifo_count=0, b_ready=1.
  - Starvation counter = 0, a_ready=1.
  - Reset mid-operation discards all queued entries and any pending output write.
- b_ready = (fifo_count < DEPTH), derived from registered count only. A same-cycle pop does not create space.
- Enqueue when b_valid && b_ready, at the tail. The entry is visible to the query and the arbiter from the next cycle.
- Arbitration, each cycle:
  - a_take = a_valid && a_ready.
  - pop = !empty && !a_take.
  - Exactly one winner, or none.
- Output register, at posedge after the arbitration cycle:
  - a_take: wAddr/wDin <= a_addr/a_data, wEna <= 1.
  - else pop: wAddr/wDin <= head, wEna <= 1.
  - else wEna <= 0; wAddr/wDin hold.
  - Latency: 1 cycle from accept to wEna. The register file commits on the following edge.
- Starvation:
  - Counter increments each cycle the FIFO is non-empty and a_take=1; clears on pop or when empty.
  - a_ready = (counter < STARVE_MAX).
  - When a_ready=0, A is held off and the head pops; counter clears. Max A hold-off is 1 cycle per STARVE_MAX.
- Busy query: combinational compare of q_addr1/q_addr2 against every valid stored entry (head through tail-1).
  - The entry being enqueued this cycle is excluded.
  - The entry currently in the output register is excluded; the register-file write bypass covers it.
- Simultaneous enqueue and pop: count unchanged, pointers both advance and wrap modulo DEPTH.
- Full FIFO with b_valid=1: b_ready=0, no enqueue; b_addr/b_data must hold.
- Ordering: no WAW protection between A and B. Issue logic stalls any instruction whose destination or sources hit q_busy.
- Empty FIFO with a_valid=0: wEna=0 next cycle.

Optional Feature:
- Macro: WB_DROP_R0_EN.
- Defined:
  - A requests with a_addr==0 are accepted (a_ready obeys the normal rule) but produce wEna=0.
  - B requests with b_addr==0 are accepted (b_ready obeys the normal rule) but not enqueued; fifo_count unchanged.
  - q_busy for address 0 is always 0.
  - Starvation counter unaffected by dropped A writes, which are treated as a_take=0, so the FIFO head pops that cycle.
- Undefined: address 0 is an ordinary register on both ports, identical to any other address.

Test Plan:
1. Reset: rst_n=0 mid-write with 3 entries queued -> wEna=0, fifo_count=0, b_ready=1, a_ready=1 immediately (async).
2. A only: a_valid=1, a_addr=5, a_data=0x1234 at cycle N -> wEna=1, wAddr=5, wDin=0x1234 at N+1; wEna=0 at N+2.
3. B fill and drain:
   - Stimulus: 4 B writes to r1..r4 back-to-back, A idle, b_valid held high.
   - Response: fifo_count reaches 4, b_ready=0, 5th request not accepted; outputs r1,r2,r3,r4 in order.
   - Query: q_addr1=3 -> q_busy1=1 until r3 leaves the FIFO.
4. Starvation: FIFO holds r7=0xAA; a_valid=1 continuously with distinct addresses.
   - A wins 8 cycles, a_ready=0 on the 9th cycle, wAddr=7/wDin=0xAA next cycle.
   - a_ready=1 again the cycle after.
5. Simultaneous push/pop at wrap: DEPTH=4, pointers at index 3, one enqueue and one pop same cycle -> count constant, next entry read from index 0 correctly.
6. r0 handling:
   - With WB_DROP_R0_EN: a_addr=0 -> wEna=0; b_addr=0 -> fifo_count stays 0.
   - Without WB_DROP_R0_EN: both produce wEna=1, wAddr=0.
